decoder: RTL and testbench



---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder.sv | 69 ++++++
 tb/tb_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for one-hot select decoders.
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int N_OUT = 4;

    // One-hot decode of a select code, gated by an active-high enable.
    function automatic logic [N_OUT-1:0] sel_onehot(
        input logic [SEL_W-1:0] a,
        input logic             e
    );
        logic [N_OUT-1:0] y;
        // NOTE: give every bit a value before the loop so no path leaves it unassigned
        // (in a combinational context that is what keeps a latch from being inferred).
        y = '0;
        for (int i = 0; i < N_OUT; i++) begin
            y[i] = e && (a == SEL_W'(i));
        end
        return y;
    endfunction

endpackage

// File: rtl/decoder.sv
// 2-to-4 one-hot select decoder with optional output register and output polarity.
module decoder
    import decoder_pkg::*;
#(
    parameter bit REGISTER_OUT = 1'b1,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] A,
    input  logic             E,
    output logic             Y_0,
    output logic             Y_1,
    output logic             Y_2,
    output logic             Y_3
);

    logic [N_OUT-1:0] dec;    // active-high decode of the current inputs
    logic [N_OUT-1:0] y_act;  // active-high select after the optional register
    logic [N_OUT-1:0] y_out;  // select at the requested output polarity

    assign dec = sel_onehot(A, E);

    generate
        if (REGISTER_OUT) begin : g_reg
            logic [N_OUT-1:0] y_q;
            logic             e_q;

            // Register the decoded select; reset drives every line to deasserted at once.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: the reset branch is asynchronous so the selects drop the moment
                // rst rises, not at the next edge; state uses non-blocking assignments.
                if (rst) begin
                    y_q <= '0;
                    e_q <= 1'b0;
                end else begin
                    y_q <= dec;
                    e_q <= E;
                end
            end

            assign y_act = y_q;

            // Inputs must be clean 0/1 whenever they are sampled outside reset.
            a_known : assert property (@(posedge clk) disable iff (rst) !$isunknown({A, E}));

            // With the enable that was captured, exactly one select is high; otherwise none.
            a_onehot : assert property (@(posedge clk) disable iff (rst)
                $countones(y_q) == (e_q ? 1 : 0));
        end else begin : g_comb
            assign y_act = dec;

            // Flag non-0/1 select inputs as soon as they change outside reset.
            always_comb begin
                if (!rst) begin
                    a_known : assert (!$isunknown({A, E}));
                end
            end
        end
    endgenerate

    assign y_out = ACTIVE_LOW ? ~y_act : y_act;

    assign Y_0 = y_out[0];
    assign Y_1 = y_out[1];
    assign Y_2 = y_out[2];
    assign Y_3 = y_out[3];

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: registered, combinational and active-low variants.
module tb_decoder;

    logic       clk;
    logic       rst;
    logic [1:0] A;
    logic       E;

    logic       r0, r1, r2, r3;  // REGISTER_OUT=1, ACTIVE_LOW=0
    logic       c0, c1, c2, c3;  // REGISTER_OUT=0, ACTIVE_LOW=0
    logic       l0, l1, l2, l3;  // REGISTER_OUT=1, ACTIVE_LOW=1
    logic       m0, m1, m2, m3;  // REGISTER_OUT=0, ACTIVE_LOW=1

    wire [3:0] y_reg     = {r3, r2, r1, r0};
    wire [3:0] y_comb    = {c3, c2, c1, c0};
    wire [3:0] y_low     = {l3, l2, l1, l0};
    wire [3:0] y_comblow = {m3, m2, m1, m0};

    int checks = 0;
    int errors = 0;

    decoder #(.REGISTER_OUT(1), .ACTIVE_LOW(0)) u_reg (
        .clk(clk), .rst(rst), .A(A), .E(E), .Y_0(r0), .Y_1(r1), .Y_2(r2), .Y_3(r3)
    );
    decoder #(.REGISTER_OUT(0), .ACTIVE_LOW(0)) u_comb (
        .clk(clk), .rst(rst), .A(A), .E(E), .Y_0(c0), .Y_1(c1), .Y_2(c2), .Y_3(c3)
    );
    decoder #(.REGISTER_OUT(1), .ACTIVE_LOW(1)) u_low (
        .clk(clk), .rst(rst), .A(A), .E(E), .Y_0(l0), .Y_1(l1), .Y_2(l2), .Y_3(l3)
    );
    decoder #(.REGISTER_OUT(0), .ACTIVE_LOW(1)) u_comblow (
        .clk(clk), .rst(rst), .A(A), .E(E), .Y_0(m0), .Y_1(m1), .Y_2(m2), .Y_3(m3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic       e;
        logic [3:0] y;  // expected {Y_3,Y_2,Y_1,Y_0}, active-high
    } vec_t;

    vec_t vecs[8];

    logic [1:0] ra;
    logic       re;
    logic       rr;
    logic [3:0] rexp;

    // Reference: the selected line index is the code itself, so it is a shifted one.
    function automatic logic [3:0] ref_select(input logic [1:0] a, input logic e);
        return e ? (4'b0001 << a) : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive new inputs away from the active edge, then wait until just after the next edge.
    task automatic step(input logic [1:0] a, input logic e);
        @(negedge clk);
        A = a;
        E = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b00, 1'b0, 4'b0000};
        vecs[1] = '{2'b01, 1'b0, 4'b0000};
        vecs[2] = '{2'b10, 1'b0, 4'b0000};
        vecs[3] = '{2'b11, 1'b0, 4'b0000};
        vecs[4] = '{2'b00, 1'b1, 4'b0001};
        vecs[5] = '{2'b01, 1'b1, 4'b0010};
        vecs[6] = '{2'b10, 1'b1, 4'b0100};
        vecs[7] = '{2'b11, 1'b1, 4'b1000};

        // Reset asserted with A=11, E=1 before any clock edge.
        rst = 1'b1;
        A   = 2'b11;
        E   = 1'b1;
        #2;
        check("reset_reg_no_edge", y_reg, 4'b0000);
        check("reset_low_no_edge", y_low, 4'b1111);
        check("reset_comb_ignores_rst", y_comb, 4'b1000);

        // First edge after release takes the decode of A/E.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_reg", y_reg, 4'b1000);
        check("release_low", y_low, 4'b0111);

        // Enable gating with A=01.
        step(2'b01, 1'b0);
        check("gate_e0_reg", y_reg, 4'b0000);
        check("gate_e0_comb", y_comb, 4'b0000);
        step(2'b01, 1'b1);
        check("gate_e1_reg", y_reg, 4'b0010);

        // Registered output shows latency: value before the edge is still the old one.
        @(negedge clk);
        A = 2'b11;
        E = 1'b1;
        #1;
        check("latency_reg_old", y_reg, 4'b0010);
        check("latency_comb_now", y_comb, 4'b1000);
        @(posedge clk);
        #1;
        check("code_change_reg", y_reg, 4'b1000);
        step(2'b11, 1'b0);
        check("code_change_e0", y_reg, 4'b0000);
        step(2'b11, 1'b1);
        check("code_change_e1", y_reg, 4'b1000);

        // Exhaustive sweep of E x A against the literal truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            A = vecs[i].a;
            E = vecs[i].e;
            #1;
            check($sformatf("sweep_comb_%0d", i), y_comb, vecs[i].y);
            check($sformatf("sweep_comblow_%0d", i), y_comblow, ~vecs[i].y);
            @(posedge clk);
            #1;
            check($sformatf("sweep_reg_%0d", i), y_reg, vecs[i].y);
            check($sformatf("sweep_low_%0d", i), y_low, ~vecs[i].y);
        end

        // Zero-latency and active-low variants with A=10, E=1.
        @(negedge clk);
        A = 2'b10;
        E = 1'b1;
        #1;
        check("comb_zero_latency", y_comb, 4'b0100);
        check("comblow_zero_latency", y_comblow, 4'b1011);
        @(posedge clk);
        #1;
        check("mid_run_y2_reg", y_reg, 4'b0100);
        check("mid_run_y2_low", y_low, 4'b1011);

        // Reset pulse between edges drops Y_2 at the pulse, not at an edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_pulse_reg", y_reg, 4'b0000);
        check("async_pulse_low", y_low, 4'b1111);
        check("async_pulse_comb", y_comb, 4'b0100);
        rst = 1'b0;
        #1;
        check("after_pulse_no_edge", y_reg, 4'b0000);
        @(posedge clk);
        #1;
        check("after_pulse_edge", y_reg, 4'b0100);

        // Randomized stimulus with occasional reset, against the reference select.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ra = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 15) == 0);
            A   = ra;
            E   = re;
            rst = rr;
            #1;
            check("rand_comb", y_comb, ref_select(ra, re));
            check("rand_comblow", y_comblow, ~ref_select(ra, re));
            if (rr) begin
                check("rand_reset_reg", y_reg, 4'b0000);
            end
            @(posedge clk);
            #1;
            rexp = rr ? 4'b0000 : ref_select(ra, re);
            check("rand_reg", y_reg, rexp);
            check("rand_low", y_low, ~rexp);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
